// File: rtl/scale_copy_engine.sv
// scale_copy_engine: reads a source image from a synchronous ROM and writes a
// scaled, centred copy into a framebuffer RAM. It supports 1x, 2x and 4x
// replication, 0.5x decimation and 0.5x 2x2 block averaging. Optional macro
// SCALE_COPY_CLEAR_EN fills the whole framebuffer with BG before each copy.
module scale_copy_engine #(
  parameter int          SRC_W   = 160,
  parameter int          SRC_H   = 120,
  parameter int          DST_W   = 640,
  parameter int          DST_H   = 480,
  parameter int          DW      = 8,
  parameter int          SRC_AW  = 15,
  parameter int          DST_AW  = 19,
  parameter int          ROM_LAT = 1,
  parameter logic [DW-1:0] BG    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic [SRC_AW-1:0] rom_addr_out,
  input  logic [DW-1:0]     rom_data_in,
  output logic [DST_AW-1:0] ram_addr_out,
  output logic [DW-1:0]     ram_data_out,
  output logic              ram_wren_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_CHECK, S_REQ, S_WAIT, S_ACC, S_WRITE, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    M_COPY = 3'd0, M_X2 = 3'd1, M_X4 = 3'd2, M_DEC = 3'd3, M_AVG = 3'd4
  } mode_e;

  localparam int MAXDIM = 4 * ((SRC_W > SRC_H) ? SRC_W : SRC_H);
  localparam int CW     = $clog2(MAXDIM);
  localparam int WTW    = $clog2(ROM_LAT + 1);
  localparam int ACW    = DW + 2;
  localparam logic [WTW-1:0] LAT_V  = WTW'(ROM_LAT);
  localparam logic [WTW-1:0] LAT_M1 = WTW'(ROM_LAT - 1);

  // Framebuffer address of the window's top-left pixel for a given window size.
  function automatic logic [DST_AW-1:0] base_of(input int ow, input int oh);
    return DST_AW'(((DST_H - oh) / 2) * DST_W + (DST_W - ow) / 2);
  endfunction

  function automatic logic fits(input int ow, input int oh);
    return (ow <= DST_W) && (oh <= DST_H);
  endfunction

  // Source offset of each fetch in a 2x2 block: (0,0), (1,0), (0,1), (1,1).
  function automatic logic [SRC_AW-1:0] fetch_off(input logic [1:0] f);
    case (f)
      2'd1:    return SRC_AW'(1);
      2'd2:    return SRC_AW'(SRC_W);
      2'd3:    return SRC_AW'(SRC_W + 1);
      default: return '0;
    endcase
  endfunction

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CW-1:0]       x_q, x_d, y_q, y_d;
  logic [1:0]          kx_q, kx_d, ky_q, ky_d;
  logic [1:0]          fetch_q, fetch_d;
  logic [WTW-1:0]      wait_q, wait_d;
  logic [ACW-1:0]      acc_q, acc_d;
  logic [SRC_AW-1:0]   src_addr_q, src_addr_d, src_row_q, src_row_d;
  logic [DST_AW-1:0]   dst_addr_q, dst_addr_d, dst_row_q, dst_row_d;
  logic [SRC_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [DST_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]       ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic                busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
`ifdef SCALE_COPY_CLEAR_EN
  localparam logic [DST_AW-1:0] CLR_LAST = DST_AW'(DST_W * DST_H - 1);
  logic [DST_AW-1:0]   clr_q, clr_d;
`endif

  // Window geometry for the latched mode.
  logic [CW-1:0]     ow_m1, oh_m1;
  logic [DST_AW-1:0] win_base;
  logic              win_fit, zoom_out, avg;
  logic [1:0]        k_m1;

  // Decode the latched mode into window size, offset and stepping.
  always_comb begin
    ow_m1    = CW'(SRC_W - 1);
    oh_m1    = CW'(SRC_H - 1);
    win_base = base_of(SRC_W, SRC_H);
    win_fit  = fits(SRC_W, SRC_H);
    k_m1     = 2'd0;
    zoom_out = 1'b0;
    avg      = 1'b0;
    case (mode_q)
      M_X2: begin
        ow_m1    = CW'(2 * SRC_W - 1);
        oh_m1    = CW'(2 * SRC_H - 1);
        win_base = base_of(2 * SRC_W, 2 * SRC_H);
        win_fit  = fits(2 * SRC_W, 2 * SRC_H);
        k_m1     = 2'd1;
      end
      M_X4: begin
        ow_m1    = CW'(4 * SRC_W - 1);
        oh_m1    = CW'(4 * SRC_H - 1);
        win_base = base_of(4 * SRC_W, 4 * SRC_H);
        win_fit  = fits(4 * SRC_W, 4 * SRC_H);
        k_m1     = 2'd3;
      end
      M_DEC, M_AVG: begin
        ow_m1    = CW'(SRC_W / 2 - 1);
        oh_m1    = CW'(SRC_H / 2 - 1);
        win_base = base_of(SRC_W / 2, SRC_H / 2);
        win_fit  = fits(SRC_W / 2, SRC_H / 2);
        zoom_out = 1'b1;
        avg      = (mode_q == M_AVG);
      end
      default: ;
    endcase
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    fetch_d    = fetch_q;
    wait_d     = wait_q;
    acc_d      = acc_q;
    src_addr_d = src_addr_q;
    src_row_d  = src_row_q;
    dst_addr_d = dst_addr_q;
    dst_row_d  = dst_row_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    cfg_err_d  = cfg_err_q;
`ifdef SCALE_COPY_CLEAR_EN
    clr_d      = clr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_err_d = 1'b0;
          case (mode)
            3'd1:    mode_d = M_X2;
            3'd2:    mode_d = M_X4;
            3'd3:    mode_d = M_DEC;
            3'd4:    mode_d = M_AVG;
            default: mode_d = M_COPY;
          endcase
`ifdef SCALE_COPY_CLEAR_EN
          state_d = S_CLEAR;
          clr_d   = '0;
`else
          state_d = S_CHECK;
`endif
        end
      end
      S_CLEAR: begin
`ifdef SCALE_COPY_CLEAR_EN
        if (clr_q == CLR_LAST) state_d = S_CHECK;
        else                   clr_d   = clr_q + DST_AW'(1);
`else
        state_d = S_CHECK;
`endif
      end
      S_CHECK: begin
        if (!win_fit) begin
          state_d   = S_DONE;
          cfg_err_d = 1'b1;
        end else begin
          state_d    = S_REQ;
          x_d        = '0;
          y_d        = '0;
          kx_d       = '0;
          ky_d       = '0;
          fetch_d    = '0;
          acc_d      = '0;
          src_addr_d = '0;
          src_row_d  = '0;
          dst_addr_d = win_base;
          dst_row_d  = win_base;
        end
      end
      S_REQ: begin
        wait_d = WTW'(1);
        // In average mode ACC stands in for the last latency cycle.
        if (avg && ROM_LAT == 1) state_d = S_ACC;
        else                     state_d = S_WAIT;
      end
      S_WAIT: begin
        if (avg) begin
          if (wait_q == LAT_M1) state_d = S_ACC;
          else                  wait_d  = wait_q + WTW'(1);
        end else if (wait_q == LAT_V) begin
          state_d    = S_WRITE;
          ram_data_d = rom_data_in;
        end else begin
          wait_d = wait_q + WTW'(1);
        end
      end
      S_ACC: begin
        acc_d = acc_q + ACW'(rom_data_in);
        if (fetch_q == 2'd3) begin
          state_d    = S_WRITE;
          ram_data_d = DW'((acc_q + ACW'(rom_data_in) + ACW'(2)) >> 2);
        end else begin
          state_d = S_REQ;
          fetch_d = fetch_q + 2'd1;
        end
      end
      S_WRITE: begin
        fetch_d = '0;
        acc_d   = '0;
        if (x_q == ow_m1) begin
          x_d  = '0;
          kx_d = '0;
          if (y_q == oh_m1) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_REQ;
            y_d        = y_q + CW'(1);
            dst_row_d  = dst_row_q + DST_AW'(DST_W);
            dst_addr_d = dst_row_q + DST_AW'(DST_W);
            if (zoom_out) begin
              src_row_d = src_row_q + SRC_AW'(2 * SRC_W);
            end else if (ky_q == k_m1) begin
              ky_d      = '0;
              src_row_d = src_row_q + SRC_AW'(SRC_W);
            end else begin
              ky_d = ky_q + 2'd1;
            end
            src_addr_d = src_row_d;
          end
        end else begin
          state_d    = S_REQ;
          x_d        = x_q + CW'(1);
          dst_addr_d = dst_addr_q + DST_AW'(1);
          if (zoom_out) begin
            src_addr_d = src_addr_q + SRC_AW'(2);
          end else if (kx_q == k_m1) begin
            kx_d       = '0;
            src_addr_d = src_addr_q + SRC_AW'(1);
          end else begin
            kx_d = kx_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    if (state_d == S_REQ) rom_addr_d = src_addr_d + fetch_off(fetch_d);
    if (state_d == S_WRITE) begin
      ram_wren_d = 1'b1;
      ram_addr_d = dst_addr_q;
    end
`ifdef SCALE_COPY_CLEAR_EN
    if (state_d == S_CLEAR) begin
      ram_wren_d = 1'b1;
      ram_addr_d = clr_d;
      ram_data_d = BG;
    end
`endif
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= M_COPY;
      x_q        <= '0;
      y_q        <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      fetch_q    <= '0;
      wait_q     <= '0;
      acc_q      <= '0;
      src_addr_q <= '0;
      src_row_q  <= '0;
      dst_addr_q <= '0;
      dst_row_q  <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef SCALE_COPY_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      fetch_q    <= fetch_d;
      wait_q     <= wait_d;
      acc_q      <= acc_d;
      src_addr_q <= src_addr_d;
      src_row_q  <= src_row_d;
      dst_addr_q <= dst_addr_d;
      dst_row_q  <= dst_row_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
`ifdef SCALE_COPY_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign rom_addr_out = rom_addr_q;
  assign ram_addr_out = ram_addr_q;
  assign ram_data_out = ram_data_q;
  assign ram_wren_out = ram_wren_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_scale_copy_engine.sv
// Bench for scale_copy_engine: 4x4 source into an 8x8 framebuffer, one
// instance with ROM latency 1 and one with ROM latency 3. Expected writes are
// queued from a reference model and popped as the DUT writes.
module tb_scale_copy_engine;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int DSTW = 8;
  localparam int DSTH = 8;
  localparam logic [7:0] BGV = 8'hA5;

  typedef struct {
    int unit;
    int addr;
    int data;
    bit clr;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, start_b;
  logic [2:0] mode_a, mode_b;
  logic [3:0] rom_addr_a, rom_addr_b;
  logic [7:0] rom_data_a, rom_data_b, rb1, rb2;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic       ram_wren_a, ram_wren_b, busy_a, busy_b, done_a, done_b, cfg_err_a, cfg_err_b;

  scale_copy_engine #(
    .SRC_W(SW), .SRC_H(SH), .DST_W(DSTW), .DST_H(DSTH), .DW(8),
    .SRC_AW(4), .DST_AW(6), .ROM_LAT(1), .BG(BGV)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
    .rom_addr_out(rom_addr_a), .rom_data_in(rom_data_a),
    .ram_addr_out(ram_addr_a), .ram_data_out(ram_data_a), .ram_wren_out(ram_wren_a),
    .busy(busy_a), .done(done_a), .cfg_err(cfg_err_a)
  );

  scale_copy_engine #(
    .SRC_W(SW), .SRC_H(SH), .DST_W(DSTW), .DST_H(DSTH), .DW(8),
    .SRC_AW(4), .DST_AW(6), .ROM_LAT(3), .BG(BGV)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .rom_addr_out(rom_addr_b), .rom_data_in(rom_data_b),
    .ram_addr_out(ram_addr_b), .ram_data_out(ram_data_b), .ram_wren_out(ram_wren_b),
    .busy(busy_b), .done(done_b), .cfg_err(cfg_err_b)
  );

  logic [7:0] rom_mem [16];
  logic [7:0] ram_model [64];

  // Synchronous ROMs: latency 1 for unit A, latency 3 for unit B.
  always @(posedge clk) rom_data_a <= rom_mem[rom_addr_a];
  always @(posedge clk) begin
    rb1        <= rom_mem[rom_addr_b];
    rb2        <= rb1;
    rom_data_b <= rb2;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_wr, n_pix, prev_pix, done_cyc, exp_gap, active;
  bit  done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: pop and compare every write, note done pulses.
  task automatic observe(input int u, input logic wren, input logic [5:0] addr,
                         input logic [7:0] data, input logic dn, input logic bz);
    wr_t e;
    if (wren) begin
      if (exp_q.size() == 0) begin
        check("wr_extra_queue_depth", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_unit", u, e.unit);
        check("wr_addr", 32'(addr), e.addr);
        check("wr_data", 32'(data), e.data);
        if (!e.clr) begin
          if (prev_pix >= 0) check("wr_gap", cyc - prev_pix, exp_gap);
          prev_pix = cyc;
          n_pix++;
        end
      end
      n_wr++;
      if (u == 0) ram_model[addr] = data;
    end
    if (dn) begin
      check("done_unit", u, active);
      check("busy_in_done", 32'(bz), 0);
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  endtask

  always @(negedge clk) begin
    observe(0, ram_wren_a, ram_addr_a, ram_data_a, done_a, busy_a);
    observe(1, ram_wren_b, ram_addr_b, ram_data_b, done_b, busy_b);
  end

  // Reference model: queue every write the given mode must produce.
  task automatic push_expected(input int u, input logic [2:0] m, output bit err, output int npix);
    int k, ow, oh, ox, oy, sx, sy, s, v;
    bit zo, av;
    wr_t e;
    zo = (m == 3'd3) || (m == 3'd4);
    av = (m == 3'd4);
    k  = (m == 3'd1) ? 2 : (m == 3'd2) ? 4 : 1;
    ow = zo ? SW / 2 : SW * k;
    oh = zo ? SH / 2 : SH * k;
    err  = (ow > DSTW) || (oh > DSTH);
    npix = 0;
`ifdef SCALE_COPY_CLEAR_EN
    for (int a = 0; a < DSTW * DSTH; a++) begin
      e = '{unit: u, addr: a, data: int'(BGV), clr: 1'b1};
      exp_q.push_back(e);
    end
`endif
    if (!err) begin
      ox = (DSTW - ow) / 2;
      oy = (DSTH - oh) / 2;
      for (int y = 0; y < oh; y++) begin
        for (int x = 0; x < ow; x++) begin
          if (zo) begin sx = 2 * x; sy = 2 * y; end
          else    begin sx = x / k; sy = y / k; end
          s = sy * SW + sx;
          if (av) v = (int'(rom_mem[s]) + int'(rom_mem[s + 1]) + int'(rom_mem[s + SW]) +
                       int'(rom_mem[s + SW + 1]) + 2) / 4;
          else    v = int'(rom_mem[s]);
          e = '{unit: u, addr: (oy + y) * DSTW + ox + x, data: v, clr: 1'b0};
          exp_q.push_back(e);
          npix++;
        end
      end
    end
  endtask

  task automatic set_start(input int u, input logic v, input logic [2:0] m);
    if (u == 0) begin start_a = v; mode_a = m; end
    else        begin start_b = v; mode_b = m; end
  endtask

  task automatic run(input int u, input logic [2:0] m, input int gap, input bit poke);
    bit err;
    int n_exp, npix_exp;
    active    = u;
    exp_gap   = gap;
    n_wr      = 0;
    n_pix     = 0;
    prev_pix  = -1;
    done_seen = 1'b0;
    push_expected(u, m, err, npix_exp);
    n_exp = exp_q.size();
    @(negedge clk);
    check("busy_before_start", 32'(u == 0 ? busy_a : busy_b), 0);
    set_start(u, 1'b1, m);
    @(negedge clk);
    set_start(u, 1'b0, m);
    check("busy_rise", 32'(u == 0 ? busy_a : busy_b), 1);
    if (poke) begin
      repeat (5) @(negedge clk);
      set_start(u, 1'b1, 3'd2);
      @(negedge clk);
      set_start(u, 1'b0, m);
    end
    for (int c = 0; c < 4000 && !done_seen; c++) @(negedge clk);
    check("done_seen", 32'(done_seen), 1);
    check("wr_count", n_wr, n_exp);
    check("pix_count", n_pix, npix_exp);
    check("cfg_err", 32'(u == 0 ? cfg_err_a : cfg_err_b), 32'(err));
    if (npix_exp > 0) check("done_latency", done_cyc - prev_pix, 1);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    bit err;
    int npix;
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) ram_model[i] = 8'hFF;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; mode_a = 3'd0; mode_b = 3'd0;
    active = 0; prev_pix = -1; done_seen = 1'b0; exp_gap = 3; n_wr = 0; n_pix = 0; done_cyc = 0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {rom_addr_a, ram_addr_a, ram_data_a, ram_wren_a, busy_a, done_a, cfg_err_a}, 0);
    check("reset_outs_b", {rom_addr_b, ram_addr_b, ram_data_b, ram_wren_b, busy_b, done_b, cfg_err_b}, 0);
    reset = 1'b0;
    @(negedge clk);

    run(0, 3'd0, 3, 1'b0);
    run(0, 3'd1, 3, 1'b1);
    check("x2_ram0", 32'(ram_model[0]), 0);
    check("x2_ram1", 32'(ram_model[1]), 0);
    check("x2_ram8", 32'(ram_model[8]), 0);
    check("x2_ram9", 32'(ram_model[9]), 0);
    check("x2_ram63", 32'(ram_model[63]), 15);
    run(0, 3'd5, 3, 1'b0);

    rom_mem[0] = 8'd10; rom_mem[1] = 8'd11; rom_mem[4] = 8'd12; rom_mem[5] = 8'd14;
    run(0, 3'd4, 9, 1'b0);
    check("avg_ram27", 32'(ram_model[27]), 12);
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i);

    run(0, 3'd2, 3, 1'b0);
    check("cfg_err_held", 32'(cfg_err_a), 1);
    run(1, 3'd3, 5, 1'b0);

    // Abort a 2x frame part-way through with reset, then rerun a 1x copy.
    active = 0; exp_gap = 3; prev_pix = -1; done_seen = 1'b0;
    push_expected(0, 3'd1, err, npix);
    @(negedge clk);
    set_start(0, 1'b1, 3'd1);
    @(negedge clk);
    set_start(0, 1'b0, 3'd1);
    repeat (30) @(negedge clk);
    check("busy_mid_frame", 32'(busy_a), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs_a", {rom_addr_a, ram_addr_a, ram_data_a, ram_wren_a, busy_a, done_a, cfg_err_a}, 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_seen), 0);
    run(0, 3'd0, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
